// File: rtl/fft_input_loader_if.sv
// Handshake/bus bundle between the FFT input loader and its neighbours:
// control (start/length/buffer), sample stream, FFT memory write port, status.
interface fft_input_loader_if #(
  parameter int MAX_LOG2   = 10,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                  start_i;
  logic [3:0]            length_log2_i;
  logic                  buffer_sel_i;
  logic [DATA_WIDTH-1:0] s_data_i;
  logic                  s_valid_i;
  logic                  s_last_i;
  logic                  s_ready_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_data_o;
  logic                  mem_write_o;
  logic                  mem_ready_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  error_o;
  logic [MAX_LOG2:0]     sample_count_o;

  // Loader side
  modport slave (
    input  start_i, length_log2_i, buffer_sel_i, s_data_i, s_valid_i, s_last_i,
           mem_ready_i,
    output s_ready_o, mem_addr_o, mem_data_o, mem_write_o, busy_o, done_o,
           error_o, sample_count_o
  );

  // Driver side (stream source, controller, memory model)
  modport master (
    output start_i, length_log2_i, buffer_sel_i, s_data_i, s_valid_i, s_last_i,
           mem_ready_i,
    input  s_ready_o, mem_addr_o, mem_data_o, mem_write_o, busy_o, done_o,
           error_o, sample_count_o
  );
endinterface

// File: rtl/fft_input_loader.sv
// FFT input loader: accepts a valid/ready stream of packed complex samples and
// writes each one into the selected ping-pong buffer at its bit-reversed index
// (length_log2 bits), one write per cycle, one cycle after acceptance.
// Optional macro FFT_LOADER_ZEROPAD_EN: an early s_last zero-pads the rest of
// the frame instead of flagging an error.
module fft_input_loader #(
  parameter int MAX_LOG2   = 10,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input logic                clk_i,
  input logic                reset_n_i,
  fft_input_loader_if.slave  bus
);
  localparam int CW = MAX_LOG2 + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    DONE = 3'd2,
    ERR  = 3'd3
`ifdef FFT_LOADER_ZEROPAD_EN
    ,PAD = 3'd4
`endif
  } state_t;

  state_t                state_q;
  logic [3:0]            len_q;
  logic [CW-1:0]         n_q;
  logic [CW-1:0]         count_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_data_q;
  logic                  mem_write_q;
  logic                  done_q;
  logic                  error_q;
  logic                  accept;
  logic                  final_beat;
  logic                  len_legal;

  // Buffer address for a sample count: base plus low len_q bits reversed
  function automatic logic [ADDR_WIDTH-1:0] wr_addr(input logic [CW-1:0] cnt);
    logic [MAX_LOG2-1:0] rev;
    for (int i = 0; i < MAX_LOG2; i++) rev[i] = cnt[MAX_LOG2-1-i];
    rev = rev >> (MAX_LOG2 - int'(len_q));
    return base_q + ADDR_WIDTH'(rev);
  endfunction

  assign len_legal  = (int'(bus.length_log2_i) >= 3) && (int'(bus.length_log2_i) <= MAX_LOG2);
  assign final_beat = (count_q == n_q - CW'(1));

  assign bus.s_ready_o      = (state_q == LOAD) && bus.mem_ready_i && (count_q < n_q);
  assign accept             = bus.s_valid_i && bus.s_ready_o;
`ifdef FFT_LOADER_ZEROPAD_EN
  assign bus.busy_o         = (state_q == LOAD) || (state_q == PAD);
`else
  assign bus.busy_o         = (state_q == LOAD);
`endif
  assign bus.mem_addr_o     = mem_addr_q;
  assign bus.mem_data_o     = mem_data_q;
  assign bus.mem_write_o    = mem_write_q;
  assign bus.done_o         = done_q;
  assign bus.error_o        = error_q;
  assign bus.sample_count_o = count_q;

  // Control FSM with registered write port and status outputs
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      len_q       <= '0;
      n_q         <= '0;
      count_q     <= '0;
      base_q      <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_write_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      mem_write_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            if (len_legal) begin
              len_q   <= bus.length_log2_i;
              n_q     <= CW'(1) << bus.length_log2_i;
              base_q  <= ADDR_WIDTH'(bus.buffer_sel_i) << MAX_LOG2;
              count_q <= '0;
              error_q <= 1'b0;
              state_q <= LOAD;
            end else begin
              error_q <= 1'b1;
              state_q <= ERR;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            mem_write_q <= 1'b1;
            mem_addr_q  <= wr_addr(count_q);
            mem_data_q  <= bus.s_data_i;
            count_q     <= count_q + CW'(1);
            if (final_beat) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              // Frame complete but untagged: still done, flagged as missing last
              if (!bus.s_last_i) error_q <= 1'b1;
            end else if (bus.s_last_i) begin
`ifdef FFT_LOADER_ZEROPAD_EN
              state_q <= PAD;
`else
              state_q <= ERR;
              error_q <= 1'b1;
`endif
            end
          end
        end
`ifdef FFT_LOADER_ZEROPAD_EN
        // Fill the remaining indices with zero samples; the last one ends the load
        PAD: begin
          if (bus.mem_ready_i) begin
            mem_write_q <= 1'b1;
            mem_addr_q  <= wr_addr(count_q);
            mem_data_q  <= '0;
            count_q     <= count_q + CW'(1);
            if (final_beat) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
`endif
        DONE:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader: natural load, buffer 1 at N=1024,
// backpressure, framing errors, illegal lengths and reset mid-load.
module tb_fft_input_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  logic [15:0] wa[$];
  logic [31:0] wd[$];
  int          wc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fft_input_loader_if #(.MAX_LOG2(10), .DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

  fft_input_loader #(.MAX_LOG2(10), .DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .bus      (bus)
  );

  // Log every memory write and done pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.mem_write_o === 1'b1) begin
      wa.push_back(bus.mem_addr_o);
      wd.push_back(bus.mem_data_o);
      wc.push_back(cyc);
    end
    if (bus.done_o === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete(); done_cnt = 0;
  endtask

  task automatic do_start(input logic [3:0] len, input logic sel);
    bus.length_log2_i = len;
    bus.buffer_sel_i  = sel;
    bus.start_i       = 1'b1;
    tick(1);
    bus.start_i       = 1'b0;
  endtask

  // Present one beat and hold it until accepted (bounded)
  task automatic send(input logic [31:0] d, input logic last);
    logic acc;
    acc = 1'b0;
    bus.s_data_i  = d;
    bus.s_valid_i = 1'b1;
    bus.s_last_i  = last;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = bus.s_ready_o;
      @(posedge clk); #1;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    bus.s_valid_i = 1'b0;
    bus.s_last_i  = 1'b0;
  endtask

  logic [15:0] exp8[8];

  initial begin
    exp8 = '{16'd0, 16'd4, 16'd2, 16'd6, 16'd1, 16'd5, 16'd3, 16'd7};
    bus.start_i = 1'b0; bus.length_log2_i = 4'd0; bus.buffer_sel_i = 1'b0;
    bus.s_data_i = '0; bus.s_valid_i = 1'b0; bus.s_last_i = 1'b0;
    bus.mem_ready_i = 1'b1;

    // Reset state
    #12;
    chk("rst_ready", bus.s_ready_o, 0);
    chk("rst_write", bus.mem_write_o, 0);
    chk("rst_addr", bus.mem_addr_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_error", bus.error_o, 0);
    chk("rst_count", bus.sample_count_o, 0);
    rst_n = 1'b1;
    tick(2);

    // Natural load, N=8, buffer 0
    clear_log();
    do_start(4'd3, 1'b0);
    chk("n8_busy", bus.busy_o, 1);
    for (int k = 0; k < 8; k++) send(32'h1000 + k, k == 7);
    chk("n8_done_pulse", bus.done_o, 1);
    chk("n8_done_write", bus.mem_write_o, 1);
    chk("n8_done_addr", bus.mem_addr_o, 7);
    chk("n8_error", bus.error_o, 0);
    tick(1);
    chk("n8_count", bus.sample_count_o, 8);
    chk("n8_busy_after", bus.busy_o, 0);
    tick(2);
    chk("n8_nwrites", wa.size(), 8);
    for (int k = 0; k < 8 && k < wa.size(); k++) begin
      chk($sformatf("n8_addr%0d", k), wa[k], exp8[k]);
      chk($sformatf("n8_data%0d", k), wd[k], 32'h1000 + k);
    end
    if (wc.size() == 8) chk("n8_consecutive", wc[7] - wc[0], 7);
    chk("n8_done_cnt", done_cnt, 1);
    chk("n8_count_hold", bus.sample_count_o, 8);

    // Buffer 1, N=1024
    clear_log();
    do_start(4'd10, 1'b1);
    for (int k = 0; k < 1024; k++) send(32'h20000 + k, k == 1023);
    tick(3);
    chk("n1024_nwrites", wa.size(), 1024);
    if (wa.size() == 1024) begin
      chk("n1024_first", wa[0], 16'h400);
      chk("n1024_second", wa[1], 16'h600);
      chk("n1024_third", wa[2], 16'h500);
      chk("n1024_last", wa[1023], 16'h7FF);
      chk("n1024_last_data", wd[1023], 32'h20000 + 1023);
    end
    chk("n1024_done_cnt", done_cnt, 1);
    chk("n1024_error", bus.error_o, 0);

    // Backpressure: memory stall and gaps in s_valid
    clear_log();
    do_start(4'd3, 1'b0);
    for (int k = 0; k < 3; k++) send(32'h3000 + k, 1'b0);
    bus.mem_ready_i = 1'b0;
    bus.s_data_i = 32'h3003; bus.s_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_ready_low%0d", i), bus.s_ready_o, 0);
      @(posedge clk); #1;
    end
    bus.mem_ready_i = 1'b1;
    bus.s_valid_i = 1'b0;
    tick(1);
    for (int k = 3; k < 8; k++) begin
      send(32'h3000 + k, k == 7);
      if (k[0]) tick(1);
    end
    tick(2);
    chk("bp_nwrites", wa.size(), 8);
    for (int k = 0; k < 8 && k < wa.size(); k++) begin
      chk($sformatf("bp_addr%0d", k), wa[k], exp8[k]);
      chk($sformatf("bp_data%0d", k), wd[k], 32'h3000 + k);
    end
    chk("bp_done_cnt", done_cnt, 1);

    // Early last at k=4
    clear_log();
    do_start(4'd3, 1'b0);
    for (int k = 0; k < 5; k++) send(32'h4000 + k, k == 4);
    chk("early_last_write_addr", bus.mem_addr_o, 1);
    tick(5);
`ifdef FFT_LOADER_ZEROPAD_EN
    chk("pad_nwrites", wa.size(), 8);
    if (wa.size() == 8) begin
      chk("pad_addr5", wa[5], 5);
      chk("pad_addr6", wa[6], 3);
      chk("pad_addr7", wa[7], 7);
      chk("pad_data7", wd[7], 0);
    end
    chk("pad_done_cnt", done_cnt, 1);
    chk("pad_error", bus.error_o, 0);
    chk("pad_count", bus.sample_count_o, 8);
`else
    chk("early_nwrites", wa.size(), 5);
    chk("early_done_cnt", done_cnt, 0);
    chk("early_error", bus.error_o, 1);
    chk("early_count", bus.sample_count_o, 5);
`endif
    chk("early_busy", bus.busy_o, 0);

    // Missing last on the final beat
    clear_log();
    do_start(4'd3, 1'b0);
    chk("ml_error_cleared", bus.error_o, 0);
    for (int k = 0; k < 8; k++) send(32'h5000 + k, 1'b0);
    chk("ml_done", bus.done_o, 1);
    chk("ml_error", bus.error_o, 1);
    tick(2);
    chk("ml_nwrites", wa.size(), 8);

    // Illegal lengths
    clear_log();
    do_start(4'd2, 1'b0);
    chk("ill2_error", bus.error_o, 1);
    chk("ill2_busy", bus.busy_o, 0);
    tick(3);
    do_start(4'd11, 1'b1);
    chk("ill11_error", bus.error_o, 1);
    chk("ill11_busy", bus.busy_o, 0);
    tick(3);
    chk("ill_nwrites", wa.size(), 0);
    chk("ill_done_cnt", done_cnt, 0);

    // Legal start clears error, then reset after 3 beats
    do_start(4'd3, 1'b0);
    chk("legal_clears_error", bus.error_o, 0);
    chk("legal_busy", bus.busy_o, 1);
    for (int k = 0; k < 3; k++) send(32'h6000 + k, 1'b0);
    chk("pre_rst_write", bus.mem_write_o, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_write", bus.mem_write_o, 0);
    chk("mid_rst_busy", bus.busy_o, 0);
    chk("mid_rst_addr", bus.mem_addr_o, 0);
    chk("mid_rst_count", bus.sample_count_o, 0);
    chk("mid_rst_ready", bus.s_ready_o, 0);
    tick(2);
    rst_n = 1'b1;
    clear_log();
    bus.s_valid_i = 1'b1; bus.s_data_i = 32'h7777;
    tick(4);
    bus.s_valid_i = 1'b0;
    chk("post_rst_nwrites", wa.size(), 0);
    chk("post_rst_busy", bus.busy_o, 0);
    chk("post_rst_error", bus.error_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
